// File: rtl/packet_byte_readout_if.sv
// Packet capture inputs and byte-stream outputs of the BLE packet readout.
// master = sniffer/host side, slave = the readout block.
interface packet_byte_readout_if #(
  parameter int DATA_W = 368
);
  logic              pkt_valid;
  logic [DATA_W-1:0] pkt_data;
  logic [8:0]        pkt_len;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_data;
  logic              out_last;

  modport master (
    output pkt_valid, pkt_data, pkt_len, out_ready,
    input  out_valid, out_data, out_last
  );

  modport slave (
    input  pkt_valid, pkt_data, pkt_len, out_ready,
    output out_valid, out_data, out_last
  );
endinterface

// File: rtl/packet_byte_readout.sv
// Buffers one sniffed BLE packet and replays it as NB header + on-air bytes; header valid 1 cycle after strobe.
// Outputs hold under out_ready=0; strobes while busy are dropped. PKT_READOUT_DROP_CNT_EN adds drop_cnt + 2nd header byte.
module packet_byte_readout #(
  parameter int PACKET_LEN_MAX = 376,
  parameter int PREAMBLE_LEN   = 8
) (
  input  logic                  symbol_clk,
  input  logic                  rst,
  packet_byte_readout_if.slave  bus,
  output logic                  busy,
  output logic                  len_err
`ifdef PKT_READOUT_DROP_CNT_EN
  ,
  output logic [7:0]            drop_cnt
`endif
);

  localparam int DATA_W = PACKET_LEN_MAX - PREAMBLE_LEN;
  localparam int NB_MAX = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
`ifdef PKT_READOUT_DROP_CNT_EN
    HDR2,
`endif
    DATA
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] pkt_buf;
  logic [5:0]        nb_q;
  logic [5:0]        rem;
  logic [5:0]        nb_in;
  logic              len_ok;
  logic              strobe_ok;
  logic              hs;
  logic              cap;
  logic [7:0]        data_byte;

  function automatic logic [7:0] bitrev(input logic [7:0] b);
    for (int i = 0; i < 8; i++) bitrev[i] = b[7-i];
  endfunction

  // Lengths below the preamble wrap to a huge NB and fail the range test.
  assign nb_in     = 6'((bus.pkt_len - 9'(PREAMBLE_LEN)) >> 3);
  assign len_ok    = (bus.pkt_len[2:0] == 3'd0) && (nb_in != 6'd0) && (nb_in <= 6'(NB_MAX));
  assign strobe_ok = bus.pkt_valid && len_ok;
  assign hs        = (state != IDLE) && bus.out_ready;
  assign cap       = (state_nxt == HDR) && (state != HDR);
  assign busy      = (state != IDLE);
  // rem counts down, so the earliest on-air byte is the highest slice.
  assign data_byte = pkt_buf[{rem, 3'b000} +: 8];

`ifdef PKT_READOUT_DROP_CNT_EN
  logic [7:0] drop_snap;
  logic       drop;

  assign drop = strobe_ok && (state != IDLE) && !cap;

  always_ff @(posedge symbol_clk or negedge rst) begin
    if (!rst) begin
      drop_cnt  <= 8'd0;
      drop_snap <= 8'd0;
    end else begin
      if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
      if (cap) drop_snap <= drop_cnt;
    end
  end
`endif

  always_comb begin
    state_nxt    = state;
    bus.out_valid = 1'b0;
    bus.out_data  = 8'h00;
    bus.out_last  = 1'b0;
    case (state)
      IDLE: begin
        if (strobe_ok) state_nxt = HDR;
      end
      HDR: begin
        bus.out_valid = 1'b1;
        bus.out_data  = {2'b00, nb_q};
`ifdef PKT_READOUT_DROP_CNT_EN
        if (hs) state_nxt = HDR2;
      end
      HDR2: begin
        bus.out_valid = 1'b1;
        bus.out_data  = drop_snap;
`endif
        if (hs) state_nxt = DATA;
      end
      DATA: begin
        bus.out_valid = 1'b1;
        bus.out_data  = bitrev(data_byte);
        bus.out_last  = (rem == 6'd0);
        if (hs && (rem == 6'd0)) state_nxt = strobe_ok ? HDR : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge symbol_clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      pkt_buf <= '0;
      nb_q    <= 6'd0;
      rem     <= 6'd0;
      len_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      len_err <= bus.pkt_valid && !len_ok;
      if (cap) begin
        pkt_buf <= bus.pkt_data;
        nb_q    <= nb_in;
      end
      if ((state != DATA) && (state_nxt == DATA)) rem <= nb_q - 6'd1;
      else if ((state == DATA) && hs && (rem != 6'd0)) rem <= rem - 6'd1;
    end
  end

endmodule

// File: tb/tb_packet_byte_readout.sv
// Directed bench for packet_byte_readout: length table, stall/reset/drop/back-to-back sequences.
module tb_packet_byte_readout;
  localparam int DATA_W = 368;
`ifdef PKT_READOUT_DROP_CNT_EN
  localparam int HN = 2;
  logic [7:0] drop_cnt;
`else
  localparam int HN = 1;
`endif

  logic symbol_clk = 1'b0;
  logic rst = 1'b0;
  logic busy, len_err;

  packet_byte_readout_if #(.DATA_W(DATA_W)) bus ();

  packet_byte_readout dut (
    .symbol_clk (symbol_clk),
    .rst        (rst),
    .bus        (bus.slave),
    .busy       (busy),
    .len_err    (len_err)
`ifdef PKT_READOUT_DROP_CNT_EN
    ,
    .drop_cnt   (drop_cnt)
`endif
  );

  always #5 symbol_clk = ~symbol_clk;

  typedef struct {
    logic [8:0] len;
    logic [7:0] hi;
    logic [7:0] lo;
    bit         err;
    int         nb;
    logic [7:0] first;
    logic [7:0] last;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  int last_idx;
  logic [8:0] sec_len;
  logic [DATA_W-1:0] sec_data;
  logic [DATA_W-1:0] img2;
  logic [DATA_W-1:0] img;
  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic strobe(input logic [8:0] len, input logic [DATA_W-1:0] data);
    bus.pkt_len   = len;
    bus.pkt_data  = data;
    bus.pkt_valid = 1'b1;
    @(posedge symbol_clk);
    #1;
    bus.pkt_valid = 1'b0;
  endtask

  // Collect bytes until the out_last handshake; optionally inject a second strobe.
  task automatic drain(input bit toggle, input int inj_cycle, input bit inj_last, input int budget);
    bit stalled = 1'b0;
    bit done = 1'b0;
    logic [8:0] sd = '0;
    got.delete();
    last_idx = -1;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge symbol_clk);
      if (bus.out_valid) begin
        if (stalled) chk("stall_hold", {23'b0, bus.out_last, bus.out_data}, {23'b0, sd});
        if (bus.out_ready) begin
          got.push_back(bus.out_data);
          stalled = 1'b0;
          if (bus.out_last) begin
            last_idx = got.size() - 1;
            done = 1'b1;
            if (inj_last) begin
              bus.pkt_len = sec_len; bus.pkt_data = sec_data; bus.pkt_valid = 1'b1;
            end
          end
        end else begin
          stalled = 1'b1;
          sd = {bus.out_last, bus.out_data};
        end
      end
      if (c == inj_cycle) begin
        bus.pkt_len = sec_len; bus.pkt_data = sec_data; bus.pkt_valid = 1'b1;
      end
      @(posedge symbol_clk);
      #1;
      bus.pkt_valid = 1'b0;
      if (toggle) bus.out_ready = ~bus.out_ready;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d bytes, no out_last within %0d cycles", got.size(), budget);
    end
  endtask

  task automatic cmp_seq(input string name);
    chk({name, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) chk(name, got[i], exp_q[i]);
    chk({name, "_last_pos"}, last_idx, got.size() - 1);
  endtask

  task automatic exp_pkt2(input logic [7:0] dc);
    exp_q = {8'h06};
    if (HN == 2) exp_q.push_back(dc);
    exp_q.push_back(8'hF0); exp_q.push_back(8'h71); exp_q.push_back(8'h91);
    exp_q.push_back(8'h7D); exp_q.push_back(8'h6B); exp_q.push_back(8'hA5);
  endtask

  initial begin
    tbl[0] = '{9'd16,  8'h01, 8'h01, 1'b0, 1,  8'h80, 8'h80};
    tbl[1] = '{9'd60,  8'h00, 8'h00, 1'b1, 0,  8'h00, 8'h00};
    tbl[2] = '{9'd400, 8'h00, 8'h00, 1'b1, 0,  8'h00, 8'h00};
    tbl[3] = '{9'd8,   8'h00, 8'h00, 1'b1, 0,  8'h00, 8'h00};
    tbl[4] = '{9'd0,   8'h00, 8'h00, 1'b1, 0,  8'h00, 8'h00};
    tbl[5] = '{9'd376, 8'h03, 8'h10, 1'b0, 46, 8'hC0, 8'h08};
    tbl[6] = '{9'd384, 8'h00, 8'h00, 1'b1, 0,  8'h00, 8'h00};
    tbl[7] = '{9'd4,   8'h00, 8'h00, 1'b1, 0,  8'h00, 8'h00};
    tbl[8] = '{9'd24,  8'h80, 8'h0F, 1'b0, 2,  8'h01, 8'hF0};

    img2 = '1;
    img2[47:0] = 48'h0F8E89BED6A5;

    bus.pkt_valid = 1'b0;
    bus.pkt_len   = '0;
    bus.pkt_data  = '0;
    bus.out_ready = 1'b0;

    // Reset state
    #2;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_len_err", len_err, 0);
`ifdef PKT_READOUT_DROP_CNT_EN
    chk("rst_drop_cnt", drop_cnt, 0);
`endif
    repeat (2) @(posedge symbol_clk);
    #1;
    rst = 1'b1;

    // Reset mid-stream with the consumer stalled
    bus.out_ready = 1'b1;
    strobe(9'd56, img2);
    chk("hdr_latency_valid", bus.out_valid, 1);
    chk("hdr_latency_data", bus.out_data, 6);
    chk("hdr_busy", busy, 1);
    repeat (2) begin @(posedge symbol_clk); #1; end
    bus.out_ready = 1'b0;
    chk("midstream_valid", bus.out_valid, 1);
    @(negedge symbol_clk);
    #1;
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_out_data", bus.out_data, 0);
    chk("midrst_out_last", bus.out_last, 0);
    chk("midrst_busy", busy, 0);
    @(posedge symbol_clk);
    #1;
    rst = 1'b1;
    @(negedge symbol_clk);
    chk("postrst_out_valid", bus.out_valid, 0);
    @(posedge symbol_clk);
    #1;

    // Full packet, consumer always ready
    bus.out_ready = 1'b1;
    strobe(9'd56, img2);
    drain(1'b0, -1, 1'b0, 40);
    exp_pkt2(8'h00);
    cmp_seq("pkt_ready");
    chk("busy_after_last", busy, 0);

    // Same packet, ready toggling
    bus.out_ready = 1'b1;
    strobe(9'd56, img2);
    drain(1'b1, -1, 1'b0, 60);
    cmp_seq("pkt_toggle");
    chk("busy_after_toggle", busy, 0);

    // Length table
    for (int v = 0; v < 9; v++) begin
      bus.out_ready = 1'b1;
      img = '1;
      if (!tbl[v].err) begin
        img[8*tbl[v].nb-1 -: 8] = tbl[v].hi;
        img[7:0] = tbl[v].lo;
      end
      strobe(tbl[v].len, img);
      chk($sformatf("len%0d_err", tbl[v].len), len_err, tbl[v].err);
      chk($sformatf("len%0d_busy", tbl[v].len), busy, !tbl[v].err);
      chk($sformatf("len%0d_valid", tbl[v].len), bus.out_valid, !tbl[v].err);
      if (tbl[v].err) begin
        @(posedge symbol_clk);
        #1;
        chk($sformatf("len%0d_err_pulse", tbl[v].len), len_err, 0);
        chk($sformatf("len%0d_idle", tbl[v].len), busy, 0);
      end else begin
        drain(1'b0, -1, 1'b0, 80);
        chk($sformatf("len%0d_count", tbl[v].len), got.size(), tbl[v].nb + HN);
        if (got.size() == tbl[v].nb + HN) begin
          chk($sformatf("len%0d_hdr", tbl[v].len), got[0], tbl[v].nb);
          chk($sformatf("len%0d_first", tbl[v].len), got[HN], tbl[v].first);
          chk($sformatf("len%0d_lastbyte", tbl[v].len), got[got.size()-1], tbl[v].last);
        end
      end
    end

    // Strobe while busy is dropped
    sec_len = 9'd16;
    sec_data = '0;
    bus.out_ready = 1'b1;
    strobe(9'd56, img2);
    drain(1'b0, 2, 1'b0, 40);
    exp_pkt2(8'h00);
    cmp_seq("drop_first_only");
    chk("drop_idle_busy", busy, 0);
    repeat (3) begin @(posedge symbol_clk); #1; end
    chk("drop_no_second", bus.out_valid, 0);
`ifdef PKT_READOUT_DROP_CNT_EN
    chk("drop_cnt_one", drop_cnt, 1);
`endif

    // Strobe on the last-byte handshake is accepted back-to-back
    sec_len = 9'd24;
    sec_data = '1;
    sec_data[15:0] = 16'h800F;
    strobe(9'd56, img2);
    drain(1'b0, -1, 1'b1, 40);
    exp_pkt2(8'h01);
    cmp_seq("b2b_first");
    chk("b2b_hdr_valid", bus.out_valid, 1);
    chk("b2b_hdr_data", bus.out_data, 2);
    chk("b2b_busy", busy, 1);
    drain(1'b0, -1, 1'b0, 40);
    exp_q = {8'h02};
    if (HN == 2) exp_q.push_back(8'h01);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'hF0);
    cmp_seq("b2b_second");
`ifdef PKT_READOUT_DROP_CNT_EN
    chk("b2b_no_drop", drop_cnt, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
